// File: rtl/expand_conv_pkg.sv
// Shared types and quantisation helper for the pointwise expand convolution engine.
// Build option: EXPAND_CONV_RELU_EN fuses a ReLU into the output quantiser.
package expand_conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default layer geometry; engines derive their own copies from their parameters.
    localparam int DEF_CHIN  = 64;
    localparam int DEF_WOUT  = 16;
    localparam int PIX_TOTAL = DEF_WOUT * DEF_WOUT;
    localparam int CH_W      = $clog2(DEF_CHIN);

    localparam int QW = 64;

    // Arithmetic shift then clamp into the representable output range.
    function automatic logic signed [QW-1:0] quant(input logic signed [QW-1:0] s,
                                                   input int width,
                                                   input int frac_bits);
        logic signed [QW-1:0] t;
        logic signed [QW-1:0] one;
        logic signed [QW-1:0] hi;
        logic signed [QW-1:0] lo;
        one = 1;
        t   = s >>> frac_bits;
        hi  = (one <<< (width - 1)) - one;
`ifdef EXPAND_CONV_RELU_EN
        lo  = '0;
`else
        lo  = -(one <<< (width - 1));
`endif
        if (t > hi) begin
            t = hi;
        end else if (t < lo) begin
            t = lo;
        end
        return t;
    endfunction

endpackage

// File: rtl/expand_mac_lane.sv
// One signed multiply-accumulate lane; exposes both the stored sum and the sum including the current beat.
module expand_mac_lane
    import expand_conv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = 38
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] pix,
    input  logic signed [WIDTH-1:0] ker,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] nxt
);

    logic signed [2*WIDTH-1:0] prod;

    assign prod = pix * ker;
    assign nxt  = acc + ACC_W'(prod);

    // Clear wins over enable so the closing beat of a pixel leaves the lane empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= nxt;
        end
    end

endmodule

// File: rtl/expand_conv_engine.sv
// Generic 1x1 convolution engine: DSP_NO parallel MAC lanes fed one input channel per beat.
// Build option: EXPAND_CONV_RELU_EN selects ReLU-clamped instead of symmetric saturated outputs.
module expand_conv_engine
    import expand_conv_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DSP_NO    = 192,
    parameter int CHIN      = 64,
    parameter int WOUT      = 16,
    parameter int FRAC_BITS = 14,
    parameter int ACC_W     = 2*WIDTH + $clog2(CHIN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [WIDTH-1:0]      ifm,
    input  logic                         ifm_valid,
    output logic                         ifm_ready,
    output logic [$clog2(CHIN)-1:0]      weight_addr,
    input  logic [DSP_NO*WIDTH-1:0]      weights_in,
    input  logic [DSP_NO*2*WIDTH-1:0]    bias_in,
    output logic [DSP_NO*WIDTH-1:0]      ofm,
    output logic                         ofm_valid,
    output logic                         layer_finish,
    input  logic                         ram_feedback
);

    localparam int PIXELS = WOUT * WOUT;
    localparam int CHW    = $clog2(CHIN);
    localparam int PXW    = $clog2(PIXELS + 1);
    localparam logic [CHW-1:0] CH_LAST = CHW'(CHIN - 1);
    localparam logic [PXW-1:0] PX_LAST = PXW'(PIXELS - 1);

    state_t         state;
    state_t         state_nxt;
    logic [CHW-1:0] ch_cnt;
    logic [PXW-1:0] pix_cnt;
    logic           beat;
    logic           last_ch;
    logic           last_pix;
    logic           clr;
    logic           vld_p1;

    function automatic logic signed [WIDTH-1:0] sat_lane(input logic signed [ACC_W-1:0] s);
        logic signed [QW-1:0] sx;
        logic signed [QW-1:0] q;
        sx = QW'(s);
        q  = quant(sx, WIDTH, FRAC_BITS);
        return WIDTH'(q);
    endfunction

    assign beat     = (state == ACC) && ifm_valid;
    assign last_ch  = beat && (ch_cnt == CH_LAST);
    assign last_pix = last_ch && (pix_cnt == PX_LAST);
    assign clr      = last_ch || (state != ACC);

    assign ifm_ready    = (state == ACC);
    assign layer_finish = (state == DONE);
    assign weight_addr  = ch_cnt;
    assign ofm_valid    = vld_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A start arriving with the finishing ram_feedback is dropped: DONE only ever returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)        state_nxt = ACC;
            ACC:     if (last_pix)     state_nxt = DONE;
            DONE:    if (ram_feedback) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_cnt  <= '0;
            pix_cnt <= '0;
        end else if (state == IDLE) begin
            ch_cnt  <= '0;
            pix_cnt <= '0;
        end else if (beat) begin
            if (last_ch) begin
                ch_cnt  <= '0;
                pix_cnt <= pix_cnt + 1'b1;
            end else begin
                ch_cnt  <= ch_cnt + 1'b1;
            end
        end
    end

    // Stage p1: quantised pixel and its valid pulse, one cycle after the closing beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= last_ch;
        end
    end

    for (genvar i = 0; i < DSP_NO; i++) begin : g_lane
        logic signed [ACC_W-1:0]   acc;
        logic signed [ACC_W-1:0]   nxt;
        logic signed [ACC_W-1:0]   bias_x;
        logic signed [WIDTH-1:0]   ofm_p1;

        assign bias_x = ACC_W'(signed'(bias_in[i*2*WIDTH +: 2*WIDTH]));

        expand_mac_lane #(
            .WIDTH (WIDTH),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .en  (beat),
            .pix (ifm),
            .ker (weights_in[i*WIDTH +: WIDTH]),
            .acc (acc),
            .nxt (nxt)
        );

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ofm_p1 <= '0;
            end else if (last_ch) begin
                ofm_p1 <= sat_lane(nxt + bias_x);
            end
        end

        assign ofm[i*WIDTH +: WIDTH] = ofm_p1;
    end

endmodule

// File: tb/tb_expand_conv_engine.sv
// Scoreboard bench for expand_conv_engine on a 4-lane, 4-channel, 2x2 layer.
module tb_expand_conv_engine;

    localparam int W    = 16;
    localparam int D    = 4;
    localparam int CHIN = 4;
    localparam int WOUT = 2;
    localparam int FRAC = 14;
    localparam int PIX  = WOUT * WOUT;
    localparam int AW   = $clog2(CHIN);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic signed [W-1:0]   ifm = '0;
    logic                  ifm_valid = 1'b0;
    logic                  ifm_ready;
    logic [AW-1:0]         weight_addr;
    logic [D*W-1:0]        weights_in;
    logic [D*2*W-1:0]      bias_in;
    logic [D*W-1:0]        ofm;
    logic                  ofm_valid;
    logic                  layer_finish;
    logic                  ram_feedback = 1'b0;

    int     wt[CHIN][D];
    longint bs[D];
    int     pixd[PIX][CHIN];

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    logic [D*W-1:0] exp_q[$];
    longint         when_q[$];
    logic [D*W-1:0] last_ofm = '0;

    expand_conv_engine #(
        .WIDTH     (W),
        .DSP_NO    (D),
        .CHIN      (CHIN),
        .WOUT      (WOUT),
        .FRAC_BITS (FRAC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ifm          (ifm),
        .ifm_valid    (ifm_valid),
        .ifm_ready    (ifm_ready),
        .weight_addr  (weight_addr),
        .weights_in   (weights_in),
        .bias_in      (bias_in),
        .ofm          (ofm),
        .ofm_valid    (ofm_valid),
        .layer_finish (layer_finish),
        .ram_feedback (ram_feedback)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ROM and bias blocks, modelled as lookups on the bench tables.
    always_comb begin
        weights_in = '0;
        bias_in    = '0;
        for (int l = 0; l < D; l++) begin
            weights_in[l*W +: W]     = W'(wt[weight_addr][l]);
            bias_in[l*2*W +: 2*W]    = (2*W)'(bs[l]);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference: dot product over channels plus bias, shift, clamp, keep low bits.
    function automatic logic [D*W-1:0] model(input int p);
        logic [D*W-1:0] v;
        longint s, t, hi, lo;
        v  = '0;
        hi = (longint'(1) <<< (W - 1)) - 1;
`ifdef EXPAND_CONV_RELU_EN
        lo = 0;
`else
        lo = -(longint'(1) <<< (W - 1));
`endif
        for (int l = 0; l < D; l++) begin
            s = bs[l];
            for (int c = 0; c < CHIN; c++) s += longint'(pixd[p][c]) * longint'(wt[c][l]);
            t = s >>> FRAC;
            if (t > hi) t = hi;
            if (t < lo) t = lo;
            v[l*W +: W] = W'(t);
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (ofm_valid) begin
                if (exp_q.size() == 0) begin
                    chk("ofm_valid_unexpected", 64'(ofm_valid), 64'd0);
                end else begin
                    chk("ofm_valid_cycle", 64'(cyc), 64'(when_q[0]));
                    chk("ofm_data", 64'(ofm), 64'(exp_q[0]));
                    last_ofm = exp_q[0];
                    void'(exp_q.pop_front());
                    void'(when_q.pop_front());
                end
            end else begin
                if (when_q.size() > 0 && when_q[0] <= cyc) begin
                    chk("ofm_valid_missing", 64'(ofm_valid), 64'd1);
                    void'(exp_q.pop_front());
                    void'(when_q.pop_front());
                end
                chk("ofm_hold", 64'(ofm), 64'(last_ofm));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_const(input int iv, input int wv, input longint b0);
        for (int p = 0; p < PIX; p++) for (int c = 0; c < CHIN; c++) pixd[p][c] = iv;
        for (int c = 0; c < CHIN; c++) for (int l = 0; l < D; l++) wt[c][l] = wv;
        for (int l = 0; l < D; l++) bs[l] = 0;
        bs[0] = b0;
    endtask

    task automatic set_random();
        for (int p = 0; p < PIX; p++)
            for (int c = 0; c < CHIN; c++) pixd[p][c] = int'($urandom_range(65535)) - 32768;
        for (int c = 0; c < CHIN; c++)
            for (int l = 0; l < D; l++) wt[c][l] = int'($urandom_range(65535)) - 32768;
        for (int l = 0; l < D; l++) bs[l] = longint'(int'($urandom));
    endtask

    task automatic start_layer();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // gap: 0 back-to-back, 1 strict toggle, >1 random idle cycles up to gap.
    task automatic drive_layer(input int gap, input bit noise);
        int g;
        bool_last: for (int p = 0; p < PIX; p++) begin
            for (int c = 0; c < CHIN; c++) begin
                ifm       = W'(pixd[p][c]);
                ifm_valid = 1'b1;
                chk("ifm_ready_acc", 64'(ifm_ready), 64'd1);
                chk("weight_addr", 64'(weight_addr), 64'(c));
                if (c == CHIN - 1) begin
                    exp_q.push_back(model(p));
                    when_q.push_back(cyc + 1);
                end
                tick();
                ifm_valid = 1'b0;
                ifm       = W'($urandom);
                g = (gap <= 1) ? gap : int'($urandom_range(gap, 0));
                for (int k = 0; k < g; k++) begin
                    if (!(p == PIX - 1 && c == CHIN - 1)) begin
                        start        = noise;
                        ram_feedback = noise;
                    end
                    tick();
                    start        = 1'b0;
                    ram_feedback = 1'b0;
                    chk("weight_addr_stall", 64'(weight_addr), 64'((c + 1) % CHIN));
                end
            end
        end
        chk("ifm_ready_done", 64'(ifm_ready), 64'd0);
        chk("layer_finish_rise", 64'(layer_finish), 64'd1);
    endtask

    task automatic finish_layer(input int hold, input bit with_start);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("layer_finish_hold", 64'(layer_finish), 64'd1);
        end
        ram_feedback = 1'b1;
        start        = with_start;
        tick();
        ram_feedback = 1'b0;
        start        = 1'b0;
        chk("layer_finish_drop", 64'(layer_finish), 64'd0);
        chk("weight_addr_idle", 64'(weight_addr), 64'd0);
        tick();
        chk("ifm_ready_idle", 64'(ifm_ready), 64'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ofm", 64'(ofm), 64'd0);
        chk("rst_ofm_valid", 64'(ofm_valid), 64'd0);
        chk("rst_layer_finish", 64'(layer_finish), 64'd0);
        chk("rst_ifm_ready", 64'(ifm_ready), 64'd0);
        chk("rst_weight_addr", 64'(weight_addr), 64'd0);
    endtask

    task automatic run_layer(input int gap, input bit noise, input int hold, input bit co_start);
        start_layer();
        drive_layer(gap, noise);
        finish_layer(hold, co_start);
    endtask

    initial begin
        set_const(0, 0, 0);
        #1 rst = 1'b0;
        #10;
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        set_const(16384, 4096, 0);
        run_layer(0, 1'b0, 5, 1'b0);

        set_const(16384, 4096, longint'(100) <<< 14);
        run_layer(0, 1'b0, 0, 1'b1);

        set_const(16384, -4096, 0);
        run_layer(0, 1'b0, 1, 1'b0);

        set_const(16384, 16384, 0);
        run_layer(0, 1'b0, 1, 1'b0);

        set_const(16384, 4096, 0);
        run_layer(1, 1'b1, 2, 1'b0);
        run_layer(0, 1'b0, 0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            set_random();
            run_layer((r % 2 == 0) ? 0 : 3, r[1], r, r[0]);
        end

        set_const(16384, 4096, 0);
        start_layer();
        for (int k = 0; k < 6; k++) begin
            ifm       = W'(pixd[k / CHIN][k % CHIN]);
            ifm_valid = 1'b1;
            if (k % CHIN == CHIN - 1) begin
                exp_q.push_back(model(k / CHIN));
                when_q.push_back(cyc + 1);
            end
            tick();
        end
        ifm_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        when_q.delete();
        last_ofm = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        set_random();
        run_layer(0, 1'b0, 1, 1'b0);

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
